// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles the three memory ports around the arbiter: the instruction-fetch
// read port (if_*), the MEM-stage read/write port (mem_*) and the single
// downstream physical memory port (pmem_*).
//
// Handshake (all three ports): a request (read/write) is held high together
// with address/byte-enables/wdata until the responder pulses resp for exactly
// one cycle; rdata is meaningful only in that resp cycle.
//
// Modports:
//   slave  - the arbiter: takes IF/MEM requests, drives their resp/rdata,
//            issues pmem requests and takes pmem resp/rdata.
//   master - the surrounding environment (pipeline + memory model).
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if;
   logic [15:0] if_memaddr;
   logic [1:0]  if_mem_byte_enable;
   logic        if_memread;
   logic        if_mem_resp;
   logic [15:0] if_mem_rdata;

   logic [15:0] mem_memaddr;
   logic [1:0]  mem_mem_byte_enable;
   logic        mem_memread;
   logic        mem_memwrite;
   logic [15:0] mem_mem_wdata;
   logic        mem_mem_resp;
   logic [15:0] mem_mem_rdata;

   logic [15:0] pmem_address;
   logic [1:0]  pmem_byte_enable;
   logic        pmem_read;
   logic        pmem_write;
   logic [15:0] pmem_wdata;
   logic        pmem_resp;
   logic [15:0] pmem_rdata;

   modport slave (
      input  if_memaddr, if_mem_byte_enable, if_memread,
      output if_mem_resp, if_mem_rdata,
      input  mem_memaddr, mem_mem_byte_enable, mem_memread, mem_memwrite, mem_mem_wdata,
      output mem_mem_resp, mem_mem_rdata,
      output pmem_address, pmem_byte_enable, pmem_read, pmem_write, pmem_wdata,
      input  pmem_resp, pmem_rdata
   );

   modport master (
      output if_memaddr, if_mem_byte_enable, if_memread,
      input  if_mem_resp, if_mem_rdata,
      output mem_memaddr, mem_mem_byte_enable, mem_memread, mem_memwrite, mem_mem_wdata,
      input  mem_mem_resp, mem_mem_rdata,
      input  pmem_address, pmem_byte_enable, pmem_read, pmem_write, pmem_wdata,
      output pmem_resp, pmem_rdata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Serialises the IF read port and the MEM read/write port onto one physical
// memory port. MEM has priority; after IF_STARVE_LIMIT consecutive MEM grants
// made while IF was waiting, IF wins the next conflict.
//
// Ports:
//   clk, rst_n         - clock, asynchronous active-low reset
//   bus (slave)        - IF, MEM and pmem handshake signals
//   busy               - high while a downstream transaction is outstanding
//   dbg_state_o        - current FSM state (IDLE=0, SERVE_IF=1, SERVE_MEM=2)
//   dbg_starve_cnt_o   - starvation counter
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter int IF_STARVE_LIMIT = 4,
   parameter int CNT_W           = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   mem_port_arbiter_if.slave    bus,
   output logic                 busy,
   output logic [1:0]           dbg_state_o,
   output logic [CNT_W-1:0]     dbg_starve_cnt_o
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      SERVE_IF  = 2'd1,
      SERVE_MEM = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(IF_STARVE_LIMIT);
   localparam bit               OVR_EN  = (IF_STARVE_LIMIT != 0);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [15:0]      addr_q, addr_d;
   logic [1:0]       be_q, be_d;
   logic             rd_q, rd_d;
   logic             wr_q, wr_d;
   logic [15:0]      wdata_q, wdata_d;

   logic mem_req;
   logic if_req;
   logic grant_if;

   assign mem_req = bus.mem_memread | bus.mem_memwrite;
   assign if_req  = bus.if_memread;
   // IF wins when alone, or on a conflict once MEM has starved it long enough.
   assign grant_if = if_req & (~mem_req | (OVR_EN & (cnt_q == LIMIT_C)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         be_q    <= '0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         be_q    <= be_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         wdata_q <= wdata_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      be_d    = be_q;
      rd_d    = rd_q;
      wr_d    = wr_q;
      wdata_d = wdata_q;
      case (state_q)
         IDLE: begin
            rd_d = 1'b0;
            wr_d = 1'b0;
            if (grant_if) begin
               addr_d  = bus.if_memaddr;
               be_d    = bus.if_mem_byte_enable;
               rd_d    = 1'b1;
               cnt_d   = '0;
               state_d = SERVE_IF;
            end else if (mem_req) begin
               addr_d  = bus.mem_memaddr;
               be_d    = bus.mem_mem_byte_enable;
               wdata_d = bus.mem_mem_wdata;
               // A simultaneous read+write request is treated as a write.
               wr_d    = bus.mem_memwrite;
               rd_d    = bus.mem_memread & ~bus.mem_memwrite;
               if (if_req && (cnt_q != LIMIT_C)) cnt_d = cnt_q + 1'b1;
               state_d = SERVE_MEM;
            end
         end
         SERVE_IF, SERVE_MEM: begin
            if (bus.pmem_resp) begin
               rd_d    = 1'b0;
               wr_d    = 1'b0;
               state_d = IDLE;
            end
         end
         default: begin
            rd_d    = 1'b0;
            wr_d    = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   assign bus.pmem_address     = addr_q;
   assign bus.pmem_byte_enable = be_q;
   assign bus.pmem_read        = rd_q;
   assign bus.pmem_write       = wr_q;
   assign bus.pmem_wdata       = wdata_q;

   // Completion is routed combinationally to whichever port owns the transfer.
   assign bus.if_mem_resp   = (state_q == SERVE_IF)  & bus.pmem_resp;
   assign bus.mem_mem_resp  = (state_q == SERVE_MEM) & bus.pmem_resp;
   assign bus.if_mem_rdata  = bus.pmem_rdata;
   assign bus.mem_mem_rdata = bus.pmem_rdata;

   assign busy             = (state_q != IDLE);
   assign dbg_state_o      = state_q;
   assign dbg_starve_cnt_o = cnt_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_IF   = 2'd1;
   localparam logic [1:0] S_MEM  = 2'd2;

   logic clk;
   logic rst_n;

   mem_port_arbiter_if bus_a ();
   mem_port_arbiter_if bus_b ();

   logic       busy_a, busy_b;
   logic [1:0] st_a, st_b;
   logic [2:0] cnt_a, cnt_b;

   mem_port_arbiter #(.IF_STARVE_LIMIT(4), .CNT_W(3)) dut_a (
      .clk              (clk),
      .rst_n            (rst_n),
      .bus              (bus_a.slave),
      .busy             (busy_a),
      .dbg_state_o      (st_a),
      .dbg_starve_cnt_o (cnt_a)
   );

   mem_port_arbiter #(.IF_STARVE_LIMIT(0), .CNT_W(3)) dut_b (
      .clk              (clk),
      .rst_n            (rst_n),
      .bus              (bus_b.slave),
      .busy             (busy_b),
      .dbg_state_o      (st_b),
      .dbg_starve_cnt_o (cnt_b)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard ----------------
   int n_chk  = 0;
   int n_fail = 0;
   logic [1:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic        if_rd;
      logic [15:0] if_addr;
      logic [1:0]  if_be;
      logic        mem_rd;
      logic        mem_wr;
      logic [15:0] mem_addr;
      logic [1:0]  mem_be;
      logic [15:0] mem_wdata;
      logic [15:0] rdata;
      logic [1:0]  exp_state;
      logic [15:0] exp_addr;
      logic [1:0]  exp_be;
      logic        exp_rd;
      logic        exp_wr;
      logic [15:0] exp_wdata;
      logic [2:0]  exp_cnt;
   } vec_t;

   vec_t vecs[6];

   // ---------------- driver tasks ----------------
   task automatic drive_idle_a();
      bus_a.if_memread = 1'b0; bus_a.mem_memread = 1'b0; bus_a.mem_memwrite = 1'b0;
      bus_a.if_memaddr = '0; bus_a.if_mem_byte_enable = '0;
      bus_a.mem_memaddr = '0; bus_a.mem_mem_byte_enable = '0; bus_a.mem_mem_wdata = '0;
      bus_a.pmem_resp = 1'b0; bus_a.pmem_rdata = '0;
   endtask

   task automatic drive_idle_b();
      bus_b.if_memread = 1'b0; bus_b.mem_memread = 1'b0; bus_b.mem_memwrite = 1'b0;
      bus_b.if_memaddr = '0; bus_b.if_mem_byte_enable = '0;
      bus_b.mem_memaddr = '0; bus_b.mem_mem_byte_enable = '0; bus_b.mem_mem_wdata = '0;
      bus_b.pmem_resp = 1'b0; bus_b.pmem_rdata = '0;
   endtask

   initial begin
      vec_t v;
      int   t;
      logic [5:0] if_seq;

      //            if_rd addr     be     mrd   mwr   maddr    mbe    wdata    rdata    state  eaddr    ebe    rd    wr    ewdata   cnt
      vecs[0] = '{1'b1, 16'h3000, 2'b11, 1'b0, 1'b0, 16'h0000, 2'b00, 16'h0000, 16'h1234, S_IF,  16'h3000, 2'b11, 1'b1, 1'b0, 16'h0000, 3'd0};
      vecs[1] = '{1'b0, 16'h0000, 2'b00, 1'b0, 1'b1, 16'h4002, 2'b01, 16'hBEEF, 16'h0000, S_MEM, 16'h4002, 2'b01, 1'b0, 1'b1, 16'hBEEF, 3'd0};
      vecs[2] = '{1'b0, 16'h0000, 2'b00, 1'b1, 1'b0, 16'h1111, 2'b10, 16'h0000, 16'hA5A5, S_MEM, 16'h1111, 2'b10, 1'b1, 1'b0, 16'h0000, 3'd0};
      vecs[3] = '{1'b0, 16'h0000, 2'b00, 1'b1, 1'b1, 16'h2222, 2'b11, 16'h0F0F, 16'h0000, S_MEM, 16'h2222, 2'b11, 1'b0, 1'b1, 16'h0F0F, 3'd0};
      vecs[4] = '{1'b1, 16'h5000, 2'b11, 1'b1, 1'b0, 16'h6000, 2'b01, 16'h0000, 16'h5A5A, S_MEM, 16'h6000, 2'b01, 1'b1, 1'b0, 16'h0000, 3'd1};
      vecs[5] = '{1'b1, 16'h7000, 2'b10, 1'b0, 1'b0, 16'h0000, 2'b00, 16'h0000, 16'hC3C3, S_IF,  16'h7000, 2'b10, 1'b1, 1'b0, 16'h0000, 3'd0};

      drive_idle_a();
      drive_idle_b();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);

      // Reset state.
      check("rst_pmem_read",  32'(bus_a.pmem_read), 0);
      check("rst_pmem_write", 32'(bus_a.pmem_write), 0);
      check("rst_pmem_addr",  32'(bus_a.pmem_address), 0);
      check("rst_busy",       32'(busy_a), 0);
      check("rst_state",      32'(st_a), 32'(S_IDLE));
      check("rst_cnt",        32'(cnt_a), 0);
      rst_n = 1'b1;
      @(negedge clk);

      // ---------------- table-driven single transactions ----------------
      for (int i = 0; i < 6; i++) begin
         v = vecs[i];
         bus_a.if_memread = v.if_rd; bus_a.if_memaddr = v.if_addr; bus_a.if_mem_byte_enable = v.if_be;
         bus_a.mem_memread = v.mem_rd; bus_a.mem_memwrite = v.mem_wr; bus_a.mem_memaddr = v.mem_addr;
         bus_a.mem_mem_byte_enable = v.mem_be; bus_a.mem_mem_wdata = v.mem_wdata;
         #1;
         check($sformatf("v%0d_no_early_issue", i), 32'(bus_a.pmem_read | bus_a.pmem_write), 0);
         @(negedge clk);
         check($sformatf("v%0d_state", i), 32'(st_a), 32'(v.exp_state));
         check($sformatf("v%0d_addr", i),  32'(bus_a.pmem_address), 32'(v.exp_addr));
         check($sformatf("v%0d_be", i),    32'(bus_a.pmem_byte_enable), 32'(v.exp_be));
         check($sformatf("v%0d_rd", i),    32'(bus_a.pmem_read), 32'(v.exp_rd));
         check($sformatf("v%0d_wr", i),    32'(bus_a.pmem_write), 32'(v.exp_wr));
         if (v.exp_wr) check($sformatf("v%0d_wdata", i), 32'(bus_a.pmem_wdata), 32'(v.exp_wdata));
         check($sformatf("v%0d_busy", i),  32'(busy_a), 1);
         check($sformatf("v%0d_cnt", i),   32'(cnt_a), 32'(v.exp_cnt));
         // Perturb inputs and abandon the request; the latched transfer must hold.
         bus_a.if_memaddr = ~v.if_addr; bus_a.mem_memaddr = ~v.mem_addr; bus_a.mem_mem_wdata = ~v.mem_wdata;
         bus_a.if_memread = 1'b0; bus_a.mem_memread = 1'b0; bus_a.mem_memwrite = 1'b0;
         repeat (2) @(negedge clk);
         check($sformatf("v%0d_hold_addr", i), 32'(bus_a.pmem_address), 32'(v.exp_addr));
         check($sformatf("v%0d_hold_rw", i),   32'({bus_a.pmem_read, bus_a.pmem_write}), 32'({v.exp_rd, v.exp_wr}));
         if (v.exp_wr) check($sformatf("v%0d_hold_wdata", i), 32'(bus_a.pmem_wdata), 32'(v.exp_wdata));
         check($sformatf("v%0d_no_resp_wait", i), 32'({bus_a.if_mem_resp, bus_a.mem_mem_resp}), 0);
         bus_a.pmem_rdata = v.rdata;
         bus_a.pmem_resp  = 1'b1;
         #1;
         check($sformatf("v%0d_if_resp", i),  32'(bus_a.if_mem_resp),  32'(v.exp_state == S_IF));
         check($sformatf("v%0d_mem_resp", i), 32'(bus_a.mem_mem_resp), 32'(v.exp_state == S_MEM));
         check($sformatf("v%0d_if_rdata", i), 32'(bus_a.if_mem_rdata), 32'(v.rdata));
         check($sformatf("v%0d_mem_rdata", i), 32'(bus_a.mem_mem_rdata), 32'(v.rdata));
         @(negedge clk);
         bus_a.pmem_resp = 1'b0;
         #1;
         check($sformatf("v%0d_cleared", i), 32'({bus_a.pmem_read, bus_a.pmem_write}), 0);
         check($sformatf("v%0d_idle", i),    32'(busy_a), 0);
         check($sformatf("v%0d_resp_1cyc", i), 32'({bus_a.if_mem_resp, bus_a.mem_mem_resp}), 0);
      end

      // ---------------- pmem_resp in IDLE is ignored ----------------
      @(negedge clk);
      bus_a.pmem_resp = 1'b1;
      #1;
      check("idle_resp_ignored", 32'({bus_a.if_mem_resp, bus_a.mem_mem_resp}), 0);
      @(negedge clk);
      bus_a.pmem_resp = 1'b0;
      check("idle_resp_state", 32'(st_a), 32'(S_IDLE));

      // ---------------- starvation, LIMIT=4 ----------------
      if_seq = 6'b010000;  // grant k: bit k set means IF expected
      for (int k = 0; k < 6; k++) exp_q.push_back(if_seq[k] ? S_IF : S_MEM);
      bus_a.if_memread = 1'b1;  bus_a.if_memaddr  = 16'h8000; bus_a.if_mem_byte_enable  = 2'b11;
      bus_a.mem_memread = 1'b1; bus_a.mem_memaddr = 16'h9000; bus_a.mem_mem_byte_enable = 2'b11;
      for (int k = 0; k < 6; k++) begin
         t = 0;
         while (!busy_a && t < 20) begin @(negedge clk); t++; end
         check($sformatf("starve_grant%0d_timeout", k), 32'(busy_a), 1);
         check($sformatf("starve_grant%0d", k), 32'(st_a), 32'(exp_q.pop_front()));
         if (k == 4) check("starve_cnt_after_if", 32'(cnt_a), 0);
         bus_a.pmem_resp = 1'b1;
         @(negedge clk);
         bus_a.pmem_resp = 1'b0;
      end
      drive_idle_a();
      @(negedge clk);

      // ---------------- LIMIT=0: pure MEM priority ----------------
      bus_b.if_memread = 1'b1;  bus_b.if_memaddr  = 16'h8000; bus_b.if_mem_byte_enable  = 2'b11;
      bus_b.mem_memread = 1'b1; bus_b.mem_memaddr = 16'h9000; bus_b.mem_mem_byte_enable = 2'b11;
      for (int k = 0; k < 6; k++) begin
         t = 0;
         while (!busy_b && t < 20) begin @(negedge clk); t++; end
         check($sformatf("nolimit_grant%0d_timeout", k), 32'(busy_b), 1);
         check($sformatf("nolimit_grant%0d", k), 32'(st_b), 32'(S_MEM));
         bus_b.pmem_resp = 1'b1;
         @(negedge clk);
         bus_b.pmem_resp = 1'b0;
      end
      check("nolimit_cnt", 32'(cnt_b), 0);
      drive_idle_b();
      @(negedge clk);

      // ---------------- reset mid-transaction ----------------
      bus_a.if_memread = 1'b1; bus_a.if_memaddr = 16'hABCD; bus_a.if_mem_byte_enable = 2'b11;
      @(negedge clk);
      check("midrst_granted", 32'(bus_a.pmem_read), 1);
      #2;
      rst_n = 1'b0;
      bus_a.pmem_resp = 1'b1;
      #1;
      check("midrst_read",    32'(bus_a.pmem_read), 0);
      check("midrst_addr",    32'(bus_a.pmem_address), 0);
      check("midrst_busy",    32'(busy_a), 0);
      check("midrst_if_resp", 32'(bus_a.if_mem_resp), 0);
      drive_idle_a();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("postrst_state", 32'(st_a), 32'(S_IDLE));
      check("postrst_read",  32'(bus_a.pmem_read), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Responder for the pipeline's two memory initiator ports: the instruction-fetch (IF) read port and the MEM-stage read/write port.
- Serialises both ports onto one physical memory port (pmem) using the same request/response handshake.
- Sits between the pipelined datapath and the cache/physical memory.
- MEM port has priority; a starvation limit guarantees IF forward progress.

Parameters:
- IF_STARVE_LIMIT, 4: consecutive MEM grants made while IF is pending before IF is forced a grant on conflict. 0 disables the override, giving pure MEM priority.
- CNT_W, 3: width of the starvation counter. Must satisfy 2^CNT_W > IF_STARVE_LIMIT.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- if_memaddr  in  16  IF address.
- if_mem_byte_enable  in  2  IF byte enables.
- if_memread  in  1  IF read request; held until if_mem_resp.
- if_mem_resp  out  1  one-cycle IF completion pulse.
- if_mem_rdata  out  16  IF read data; valid when if_mem_resp=1.
- mem_memaddr  in  16  MEM address.
- mem_mem_byte_enable  in  2  MEM byte enables.
- mem_memread  in  1  MEM read request.
- mem_memwrite  in  1  MEM write request.
- mem_mem_wdata  in  16  MEM write data.
- mem_mem_resp  out  1  one-cycle MEM completion pulse.
- mem_mem_rdata  out  16  MEM read data; valid when mem_mem_resp=1.
- pmem_address  out  16  downstream address (registered).
- pmem_byte_enable  out  2  downstream byte enables (registered).
- pmem_read  out  1  downstream read (registered).
- pmem_write  out  1  downstream write (registered).
- pmem_wdata  out  16  downstream write data (registered).
- pmem_resp  in  1  downstream completion pulse.
- pmem_rdata  in  16  downstream read data; valid with pmem_resp.
- busy  out  1  high while in a SERVE state.

Behaviour:
- Clock/reset:
  - One clock domain, clk.
  - Reset is asynchronous and active-low on rst_n.
  - Reset forces state IDLE, starvation counter 0, and all pmem_* outputs, both resp outputs and busy to 0. This holds even mid-transaction; the downstream request is abandoned.
- Requests:
  - mem_req = mem_memread | mem_memwrite.
  - If mem_memread and mem_memwrite are both 1, treat the request as a write.
  - if_req = if_memread.
- States: IDLE, SERVE_IF, SERVE_MEM.
- IDLE:
  - Only mem_req: latch MEM address, byte enables, wdata and read/write into pmem_* registers; next state SERVE_MEM.
  - Only if_req: latch IF address and byte enables, pmem_read=1, pmem_write=0; next state SERVE_IF.
  - Both: grant IF if IF_STARVE_LIMIT≠0 and the counter equals IF_STARVE_LIMIT; otherwise grant MEM.
  - Neither: stay in IDLE with pmem_read=pmem_write=0.
- Latency: a request seen in IDLE appears on pmem_* on the next cycle.
- SERVE_x:
  - pmem_* hold stable until pmem_resp.
  - In the cycle pmem_resp=1:
    - the granted port's resp output is 1, combinationally from pmem_resp;
    - the other port's resp is 0;
    - pmem_read/pmem_write clear at the edge;
    - next state IDLE.
  - Requester inputs are ignored while in a SERVE state.
- Read data: if_mem_rdata and mem_mem_rdata both equal pmem_rdata at all times; data is meaningful only with the matching resp.
- Minimum turnaround: request in IDLE → pmem issue (+1 cycle) → resp (≥+1 cycle) → IDLE. The next grant cannot occur before the cycle after resp.
- Starvation counter:
  - Increments, saturating at IF_STARVE_LIMIT, when MEM is granted in IDLE while if_req=1.
  - Clears to 0 when IF is granted.
  - Otherwise unchanged.
- Abandoned request: if a requester deasserts after latch, the downstream transaction still completes and resp is still pulsed. Requesters ignore an unexpected resp.
- resp never asserts in IDLE. A pmem_resp arriving in IDLE is ignored.
- Byte enables are forwarded unchanged for reads and writes.
- No address alignment or arithmetic is performed.

Test Plan:
- Reset mid-transaction: IF read granted, assert rst_n=0 before pmem_resp → all outputs 0 immediately; after release, state IDLE with no pmem request.
- Single IF read: if_memaddr=0x3000, be=2'b11, pmem returns 0x1234 after 3 cycles → pmem_read rises 1 cycle after the request; if_mem_resp=1 with if_mem_rdata=0x1234 for exactly 1 cycle; mem_mem_resp stays 0.
- MEM write: addr 0x4002, wdata 0xBEEF, be=2'b01 → pmem_write=1, pmem_address=0x4002, pmem_wdata=0xBEEF, pmem_byte_enable=2'b01, all stable until pmem_resp; then mem_mem_resp pulses.
- Simultaneous requests, LIMIT=4: both held continuously (MEM re-requests each time) → grant order MEM×4, then IF, then MEM; counter reads 0 after the IF grant.
- LIMIT=0 with both requests held → IF never granted while mem_req is continuously high.
- Changing inputs during SERVE_MEM: alter mem_memaddr after latch → pmem_address keeps the latched value; MEM drops its request before resp → resp still pulsed once and state returns to IDLE.
